// File: rtl/nes_mem_pkg.sv
// Shared constants and FSM state type for the memory dump controller.
// Imported by the controller and its output buffer.
package nes_mem_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultAddrW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } dump_state_e;

endpackage

// File: rtl/mem_dump_fifo.sv
// Two-entry output buffer holding read data, source address and final-beat flag.
// Flush empties it in one cycle; flush takes priority over a simultaneous push.
module mem_dump_fifo
  import nes_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_last,
  output logic [1:0]        count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  logic [DATA_W-1:0] data_q [2];
  logic [ADDR_W-1:0] addr_q [2];
  logic              last_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              push;
  logic              pop;

  assign push      = in_valid && (count_q != 2'd2);
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = data_q[rd_ptr_q];
  assign out_addr  = addr_q[rd_ptr_q];
  // Stale entries may hold a set flag; only report it on a real beat.
  assign out_last  = out_valid && last_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= in_data;
        addr_q[wr_ptr_q] <= in_addr;
        last_q[wr_ptr_q] <= in_last;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_dump_ctrl.sv
// Streams a contiguous (wrapping) range of a synchronous-read memory out as
// valid/ready beats tagged with source address and a final-beat flag.
module mem_dump_ctrl
  import nes_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dump_req,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0]   RemOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] infl_addr_q;
  logic              infl_last_q;

  logic              rd_en;
  logic              flush;
  logic              pop;
  logic [1:0]        fifo_count;
  logic [2:0]        occ;

  assign pop = out_valid && out_ready;
  // Occupancy after this edge if no read issues: held + in flight - leaving.
  assign occ = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    rd_en   = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dump_req && !abort) begin
          if (length == '0) begin
            state_d = StDone;
          end else begin
            addr_d  = start_addr;
            rem_d   = length;
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = StIdle;
        end else if (occ < 3'd2) begin
          rd_en  = 1'b1;
          addr_d = addr_q + AddrOne;
          rem_d  = rem_q - RemOne;
          if (rem_q == RemOne) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = StIdle;
        end else if (pop && out_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      rem_q       <= '0;
      inflight_q  <= 1'b0;
      infl_addr_q <= '0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      inflight_q  <= rd_en;
      infl_addr_q <= addr_q;
      infl_last_q <= (rem_q == RemOne);
    end
  end

  assign mem_rd_en   = rd_en;
  assign mem_rd_addr = addr_q;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);

  mem_dump_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (inflight_q && !flush),
    .in_data   (mem_rd_data),
    .in_addr   (infl_addr_q),
    .in_last   (infl_last_q),
    .count     (fifo_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Directed bench for mem_dump_ctrl: table-driven dumps plus abort and reset sequences.
module tb_mem_dump_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dump_req;
  logic [15:0] start_addr;
  logic [16:0] length;
  logic        abort;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic [7:0]  mem_rd_data = 8'h00;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] out_addr;
  logic        out_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_dump_ctrl #(
    .DATA_W (8),
    .ADDR_W (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dump_req    (dump_req),
    .start_addr  (start_addr),
    .length      (length),
    .abort       (abort),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Synchronous-read memory: data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= memf(mem_rd_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] sa;
    logic [16:0] len;
    logic [3:0]  pat;
    int          n;
    logic [15:0] last_a;
    bit          inj;
  } vec_t;

  vec_t vecs[6];

  task automatic run_dump(input vec_t v);
    int          beats = 0;
    int          dones = 0;
    int          first_v = -1;
    int          last_k = -1;
    int          done_k = -1;
    int          busy_n = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  hd = '0;
    logic [15:0] ha = '0;
    logic        hl = 1'b0;
    logic [15:0] ea = v.sa;
    logic [15:0] last_a = '0;
    @(negedge clk);
    start_addr = v.sa;
    length     = v.len;
    dump_req   = 1'b1;
    out_ready  = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      dump_req = v.inj && (k == 2);
      if (v.inj && k == 2) begin
        start_addr = 16'h0900;
        length     = 17'd5;
      end
      if (k == 1) chk("rd_en_latency", 32'(mem_rd_en), 32'(v.len != 0));
      if (busy) busy_n++;
      if (done) begin
        dones++;
        done_k = k;
      end
      if (out_valid && first_v < 0) first_v = k;
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(hd));
        chk("hold_addr", 32'(out_addr), 32'(ha));
        chk("hold_last", 32'(out_last), 32'(hl));
      end
      out_ready = v.pat[(k - 1) % 4];
      if (out_valid && out_ready) begin
        chk("beat_addr", 32'(out_addr), 32'(ea));
        chk("beat_data", 32'(out_data), 32'(memf(ea)));
        chk("beat_last", 32'(out_last), 32'(beats == v.n - 1));
        if (out_last) begin
          last_k = k;
          last_a = out_addr;
        end
        beats++;
        ea = ea + 16'd1;
      end
      prev_stall = out_valid && !out_ready;
      hd = out_data;
      ha = out_addr;
      hl = out_last;
      if (done_k > 0 && k >= done_k + 6) break;
    end
    chk("beat_count", 32'(beats), 32'(v.n));
    chk("done_pulses", 32'(dones), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    if (v.n > 0) begin
      chk("first_valid_cycle", 32'(first_v), 32'd3);
      chk("done_after_last", 32'(done_k), 32'(last_k + 1));
      chk("last_beat_addr", 32'(last_a), 32'(v.last_a));
    end else begin
      chk("zero_len_busy_cycles", 32'(busy_n), 32'd1);
      chk("zero_len_done_cycle", 32'(done_k), 32'd1);
    end
    out_ready = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_mem_rd_addr"}, 32'(mem_rd_addr), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_out_addr"}, 32'(out_addr), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int beats;
    int dones;
    int outs;
    logic [15:0] ea;
    vecs[0] = '{sa: 16'h0010, len: 17'd4,  pat: 4'b1111, n: 4,  last_a: 16'h0013, inj: 1'b0};
    vecs[1] = '{sa: 16'hFFFE, len: 17'd4,  pat: 4'b1111, n: 4,  last_a: 16'h0001, inj: 1'b0};
    vecs[2] = '{sa: 16'h0100, len: 17'd16, pat: 4'b1001, n: 16, last_a: 16'h010F, inj: 1'b0};
    vecs[3] = '{sa: 16'h1234, len: 17'd0,  pat: 4'b1111, n: 0,  last_a: 16'h0000, inj: 1'b0};
    vecs[4] = '{sa: 16'h0500, len: 17'd4,  pat: 4'b1111, n: 4,  last_a: 16'h0503, inj: 1'b1};
    vecs[5] = '{sa: 16'h00FF, len: 17'd3,  pat: 4'b0101, n: 3,  last_a: 16'h0101, inj: 1'b0};

    reset_n    = 1'b0;
    dump_req   = 1'b0;
    start_addr = '0;
    length     = '0;
    abort      = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_dump(vecs[i]);

    // Abort after beat 3 of an 8-word dump.
    @(negedge clk);
    start_addr = 16'h0200;
    length     = 17'd8;
    dump_req   = 1'b1;
    out_ready  = 1'b1;
    beats      = 0;
    ea         = 16'h0200;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      dump_req = 1'b0;
      if (out_valid && out_ready) begin
        chk("abort_beat_addr", 32'(out_addr), 32'(ea));
        ea = ea + 16'd1;
        beats++;
        if (beats == 3) break;
      end
    end
    chk("abort_pre_beats", 32'(beats), 32'd3);
    @(negedge clk);
    abort     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rd_en", 32'(mem_rd_en), 32'd0);
    out_ready = 1'b1;
    dones = 0;
    outs  = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dones++;
      if (out_valid) outs++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_no_beats", 32'(outs), 32'd0);
    run_dump('{sa: 16'h0300, len: 17'd2, pat: 4'b1111, n: 2, last_a: 16'h0301, inj: 1'b0});

    // Abort together with a request in IDLE: nothing starts.
    @(negedge clk);
    start_addr = 16'h0700;
    length     = 17'd4;
    dump_req   = 1'b1;
    abort      = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    abort    = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_rd_en", 32'(mem_rd_en), 32'd0);
    outs = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid || done || busy) outs++;
    end
    chk("idle_abort_quiet", 32'(outs), 32'd0);

    // Reset in the middle of a dump.
    @(negedge clk);
    start_addr = 16'h0600;
    length     = 17'd8;
    dump_req   = 1'b1;
    out_ready  = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    reset_n = 1'b1;
    outs = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || done || busy || mem_rd_en) outs++;
    end
    chk("post_reset_quiet", 32'(outs), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
